// File: rtl/uart_rx_if.sv
// Receive-side stream bundle for uart_rx: FIFO head byte, valid/ready handshake
// and the two error pulses.
interface uart_rx_if;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       overflow;
    logic       frame_err;

    modport master (
        output rdata,
        output rvalid,
        output overflow,
        output frame_err,
        input  rready
    );

    modport slave (
        input  rdata,
        input  rvalid,
        input  overflow,
        input  frame_err,
        output rready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, break detection and a first-word-fall-through
// byte FIFO presented on a valid/ready stream.
module uart_rx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_ASIZE = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_uart_rx,
    uart_rx_if.master bus
);
    localparam int              CW        = $clog2(CLK_DIV);
    localparam int              DEPTH     = 1 << FIFO_ASIZE;
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_sync;
    logic                  w_rxs;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_idx;
    logic [7:0]            r_sr;
    logic                  w_half;
    logic                  w_bit_end;
    logic                  w_cnt_run;
    logic                  w_shift;
    logic                  w_good;
    logic                  w_bad;

    logic [FIFO_ASIZE:0]   r_wptr;
    logic [FIFO_ASIZE:0]   r_rptr;
    logic [7:0]            r_mem [DEPTH];
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  r_overflow;
    logic                  r_frame_err;

    // Both stages reset to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_uart_rx};
        end
    end

    assign w_rxs     = r_sync[1];
    assign w_half    = (r_cnt == HALF_LAST);
    assign w_bit_end = (r_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rxs) w_next = S_START;
            end
            S_START: begin
                if (w_half) w_next = w_rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_idx == 3'd7)) w_next = S_STOP;
            end
            S_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (w_bit_end) w_next = w_rxs ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rxs) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_run = 1'b0;
        w_shift   = 1'b0;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        unique case (r_state)
            S_START: begin
                w_cnt_run = !w_half;
            end
            S_DATA: begin
                w_cnt_run = !w_bit_end;
                w_shift   = w_bit_end;
            end
            S_STOP: begin
                w_cnt_run = !w_bit_end;
                w_good    = w_bit_end && w_rxs;
                w_bad     = w_bit_end && !w_rxs;
            end
            default: begin
                w_cnt_run = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_sr  <= 8'h00;
        end else begin
            r_cnt <= w_cnt_run ? r_cnt + 1'b1 : '0;
            if (r_state != S_DATA) begin
                r_idx <= 3'd0;
            end else if (w_shift) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_shift) begin
                r_sr <= {w_rxs, r_sr[7:1]};
            end
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_ASIZE] != r_rptr[FIFO_ASIZE]) &&
                     (r_wptr[FIFO_ASIZE-1:0] == r_rptr[FIFO_ASIZE-1:0]);
    assign w_pop   = !w_empty && bus.rready;
    assign w_push  = w_good && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_overflow  <= w_good && !w_push;
            r_frame_err <= w_bad;
        end
    end

    // When full with a same-cycle pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr[FIFO_ASIZE-1:0]] <= r_sr;
        end
    end

    assign bus.rvalid    = !w_empty;
    assign bus.rdata     = w_empty ? 8'h00 : r_mem[r_rptr[FIFO_ASIZE-1:0]];
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of single frames, hand-written corner sequences and a
// randomized run scored against an ordered model of the good bytes sent.
module tb_uart_rx;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_ASIZE = 4;
    // Edge index of the stop sample, counted from the edge just before the start bit is driven.
    localparam int STOP_OFS   = 1 + 2 + CLK_DIV / 2 + 9 * CLK_DIV;

    logic clk = 1'b0;
    logic rst;
    logic rx_line;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_ASIZE(FIFO_ASIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_uart_rx(rx_line),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_pop = 0;
    int         n_ovf = 0;
    int         n_ferr = 0;
    int         n_vcyc = 0;
    int         rise_cyc = -1;
    logic [7:0] rise_data = 8'h00;
    logic       prev_v = 1'b0;
    logic [7:0] pop_log [0:1023];

    always @(negedge clk) begin
        if (bus.rvalid && bus.rready) begin
            pop_log[n_pop[9:0]] <= bus.rdata;
            n_pop <= n_pop + 1;
        end
        if (bus.overflow)  n_ovf  <= n_ovf + 1;
        if (bus.frame_err) n_ferr <= n_ferr + 1;
        if (bus.rvalid)    n_vcyc <= n_vcyc + 1;
        if (bus.rvalid && !prev_v) begin
            rise_cyc  <= cyc;
            rise_data <= bus.rdata;
        end
        prev_v <= bus.rvalid;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the line at the stop level so a bad stop can be stretched into a break.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_line = 1'b0;
        tick(CLK_DIV);
        for (int k = 0; k < 8; k++) begin
            rx_line = b[k];
            tick(CLK_DIV);
        end
        rx_line = stop;
        tick(CLK_DIV);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        bus.rready = 1'b1;
        while (bus.rvalid && guard < 200) begin
            tick(1);
            guard++;
        end
        check({name, "_drain_done"}, int'(bus.rvalid), 0);
        bus.rready = 1'b0;
        tick(1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_stored;
        int         exp_ferr;
    } vec_t;

    vec_t       tbl [7];
    int         s_pop, s_ovf, s_ferr, s_vcyc, p0;
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic       st;
    int         exp_ferr_rand;
    bit         send_done;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 0};
        tbl[3] = '{8'h3C, 1'b0, 0, 1};
        tbl[4] = '{8'h01, 1'b1, 1, 0};
        tbl[5] = '{8'h80, 1'b1, 1, 0};
        tbl[6] = '{8'hC3, 1'b0, 0, 1};

        rst        = 1'b1;
        rx_line    = 1'b1;
        bus.rready = 1'b0;
        tick(3);
        check("reset_rvalid",    int'(bus.rvalid),    0);
        check("reset_rdata",     int'(bus.rdata),     0);
        check("reset_overflow",  int'(bus.overflow),  0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        rst = 1'b0;
        tick(5);

        // Single byte: exact rvalid timing and width.
        bus.rready = 1'b1;
        s_vcyc = n_vcyc; s_ovf = n_ovf; s_ferr = n_ferr;
        p0 = cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("single_rise_time", rise_cyc - p0, STOP_OFS);
        check("single_rdata",     int'(rise_data), 'hA5);
        check("single_vcycles",   n_vcyc - s_vcyc, 1);
        check("single_no_ovf",    n_ovf - s_ovf, 0);
        check("single_no_ferr",   n_ferr - s_ferr, 0);

        // Table of single frames.
        for (int i = 0; i < 7; i++) begin
            s_pop = n_pop; s_ferr = n_ferr;
            bus.rready = 1'b1;
            send_frame(tbl[i].data, tbl[i].stop);
            if (!tbl[i].stop) begin
                tick(40);
                rx_line = 1'b1;
            end
            tick(30);
            check($sformatf("tbl%0d_stored", i), n_pop - s_pop, tbl[i].exp_stored);
            if (tbl[i].exp_stored != 0)
                check($sformatf("tbl%0d_data", i), int'(pop_log[s_pop[9:0]]), int'(tbl[i].data));
            check($sformatf("tbl%0d_ferr", i), n_ferr - s_ferr, tbl[i].exp_ferr);
        end

        // Overflow: 17 back-to-back bytes, nothing consumed.
        bus.rready = 1'b0;
        s_ovf = n_ovf;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        check("ovf_none_at_16", n_ovf - s_ovf, 0);
        send_frame(8'h10, 1'b1);
        tick(2);
        check("ovf_once_at_17", n_ovf - s_ovf, 1);
        s_pop = n_pop;
        drain("ovf");
        check("ovf_drain_count", n_pop - s_pop, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("ovf_order%0d", i), int'(pop_log[10'(s_pop + i)]), i);

        // Glitch rejection.
        s_pop = n_pop; s_ovf = n_ovf; s_ferr = n_ferr;
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        tick(40);
        check("glitch_no_push", int'(bus.rvalid), 0);
        check("glitch_no_ferr", n_ferr - s_ferr, 0);
        check("glitch_no_ovf",  n_ovf - s_ovf, 0);
        bus.rready = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(10);
        check("glitch_then_byte", int'(pop_log[s_pop[9:0]]), 'h5A);

        // Framing error with a held-low line, then a clean byte.
        s_pop = n_pop; s_ferr = n_ferr;
        send_frame(8'h3C, 1'b0);
        tick(40);
        rx_line = 1'b1;
        tick(20);
        send_frame(8'h55, 1'b1);
        tick(20);
        check("ferr_once",   n_ferr - s_ferr, 1);
        check("ferr_stored", n_pop - s_pop, 1);
        check("ferr_next",   int'(pop_log[s_pop[9:0]]), 'h55);

        // Push and pop in the same cycle while full.
        bus.rready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'h60 + 8'(i), 1'b1);
        s_ovf = n_ovf; s_pop = n_pop;
        fork
            send_frame(8'h77, 1'b1);
            begin
                tick(STOP_OFS - 1);
                bus.rready = 1'b1;
                tick(1);
                bus.rready = 1'b0;
            end
        join
        tick(5);
        check("full_pp_no_ovf", n_ovf - s_ovf, 0);
        check("full_pp_popped", n_pop - s_pop, 1);
        check("full_pp_head",   int'(pop_log[s_pop[9:0]]), 'h60);
        drain("full_pp");
        check("full_pp_count", n_pop - s_pop, 17);
        for (int i = 1; i < 16; i++)
            check($sformatf("full_pp_order%0d", i), int'(pop_log[10'(s_pop + i)]), 'h60 + i);
        check("full_pp_last", int'(pop_log[10'(s_pop + 16)]), 'h77);

        // Reset during bit 4 with two bytes buffered.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        fork
            send_frame(8'h81, 1'b1);
            begin
                tick(5 * CLK_DIV + CLK_DIV / 2);
                rst = 1'b1;
                tick(1);
                check("rst_rvalid",    int'(bus.rvalid),    0);
                check("rst_rdata",     int'(bus.rdata),     0);
                check("rst_overflow",  int'(bus.overflow),  0);
                check("rst_frame_err", int'(bus.frame_err), 0);
                rst = 1'b0;
            end
        join
        // The line was low at reset release, so a stray frame may follow; let it finish and discard.
        tick(400);
        drain("rst_flush");
        s_pop = n_pop;
        bus.rready = 1'b1;
        send_frame(8'h42, 1'b1);
        tick(20);
        check("rst_after_count", n_pop - s_pop, 1);
        check("rst_after_data",  int'(pop_log[s_pop[9:0]]), 'h42);

        // Randomized frames, gaps, bad stops and consumer stalls.
        s_pop = n_pop; s_ovf = n_ovf; s_ferr = n_ferr;
        exp_ferr_rand = 0;
        send_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    b  = 8'($urandom);
                    st = ($urandom_range(0, 5) != 0);
                    send_frame(b, st);
                    if (st) begin
                        exp_q.push_back(b);
                        tick($urandom_range(0, 20));
                    end else begin
                        exp_ferr_rand++;
                        tick($urandom_range(0, 30));
                        rx_line = 1'b1;
                        tick(4 + $urandom_range(0, 10));
                    end
                end
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    bus.rready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        drain("rand");
        check("rand_count", n_pop - s_pop, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("rand_byte%0d", i), int'(pop_log[10'(s_pop + i)]), int'(exp_q[i]));
        check("rand_ferr", n_ferr - s_ferr, exp_ferr_rand);
        check("rand_ovf",  n_ovf - s_ovf, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
